// File: rtl/mat_mul_pkg.sv
// Shared types and constants for the BRAM-driven systolic matrix multiplier.
// Holds the FSM states, SP control addresses, mode encodings and the dimension clamp helper.
// No logic lives here, so there is no latency or backpressure to describe.
package mat_mul_pkg;

  typedef enum logic [2:0] {IDLE, CFG, LOAD, COMPUTE, WRITE, DONE} state_t;

  localparam logic [31:0] SP_START = 32'd0;
  localparam logic [31:0] SP_MODE  = 32'd4;
  localparam logic [31:0] SP_M     = 32'd8;
  localparam logic [31:0] SP_K     = 32'd12;
  localparam logic [31:0] SP_N     = 32'd16;
  localparam logic [31:0] SP_DONE  = 32'd100;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  localparam int DIM_W = 8;

  typedef struct packed {
    logic             mode;
    logic [DIM_W-1:0] m;
    logic [DIM_W-1:0] k;
    logic [DIM_W-1:0] n;
  } cfg_t;

  // Out-of-range dimensions are pulled into 1..lim rather than rejected.
  function automatic logic [DIM_W-1:0] clamp_dim(input logic [31:0] raw, input int unsigned lim);
    if (raw == 32'd0) return DIM_W'(1);
    if (raw > 32'(lim)) return DIM_W'(lim);
    return raw[DIM_W-1:0];
  endfunction

endpackage

// File: rtl/mat_mul_pe.sv
// Signed MAC cell: activation/weight pass through one register each, products accumulate in place.
// Latency: one cycle pass-through, accumulator updated on the edge ending each enabled cycle.
// No backpressure: clr/en are driven by the controller and always honoured.
module mat_mul_pe
  import mat_mul_pkg::*;
#(
  parameter int ACT_DATA_WIDTH = 8,
  parameter int WGT_DATA_WIDTH = 8,
  parameter int PE_OUT_WIDTH   = 32
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clr,
  input  logic                             en,
  input  logic signed [ACT_DATA_WIDTH-1:0] a_in,
  input  logic signed [WGT_DATA_WIDTH-1:0] w_in,
  output logic signed [ACT_DATA_WIDTH-1:0] a_out,
  output logic signed [WGT_DATA_WIDTH-1:0] w_out,
  output logic signed [PE_OUT_WIDTH-1:0]   acc
);

  logic signed [ACT_DATA_WIDTH+WGT_DATA_WIDTH-1:0] prod;
  assign prod = a_in * w_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_out <= '0;
      w_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      w_out <= w_in;
      if (clr)
        acc <= '0;
      else if (en)
        acc <= acc + PE_OUT_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/mat_mul_system.sv
// O = A*W from BRAMs through an output-accumulating systolic array, started and acknowledged via SP BRAM.
// Latency: ~4 cfg + max(MK,KN)+1 load + M+K+N-2 compute + M*N write + 3 done cycles.
// No backpressure: all BRAMs are fixed one-cycle-read memories, one access per cycle.
module mat_mul_system
  import mat_mul_pkg::*;
#(
  parameter int SYS_ARR_SIZE   = 8,
  parameter int ACT_DATA_WIDTH = 8,
  parameter int WGT_DATA_WIDTH = 8,
  parameter int PE_OUT_WIDTH   = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] addr_sp_bram,
  output logic        enable_sp_bram,
  input  logic [31:0] data_out_sp_bram,
  output logic [3:0]  w_enable_sp_bram,
  output logic [31:0] data_in_sp_bram,
  output logic [31:0] addr_a_bram,
  output logic        enable_a_bram,
  input  logic [31:0] data_out_a_bram,
  output logic [31:0] addr_w_bram,
  output logic        enable_w_bram,
  input  logic [31:0] data_out_w_bram,
  output logic [31:0] addr_o_bram,
  output logic        enable_o_bram,
  output logic [3:0]  w_enable_o_bram,
  output logic [31:0] data_in_o_bram
);

  localparam int S  = SYS_ARR_SIZE;
  localparam int IW = $clog2(SYS_ARR_SIZE);

  state_t           state;
  cfg_t             cfg;
  logic [1:0]       cfg_cnt;
  logic [1:0]       done_ph;
  logic             holdoff;
  logic [15:0]      idx;
  logic [DIM_W-1:0] am, ak, wk, wn, t, om, on;
  logic             a_cap_vld, w_cap_vld;
  logic [DIM_W-1:0] a_cap_r, a_cap_c, w_cap_r, w_cap_c;

  logic signed [ACT_DATA_WIDTH-1:0] a_buf [S][S];
  logic signed [WGT_DATA_WIDTH-1:0] w_buf [S][S];

  logic signed [ACT_DATA_WIDTH-1:0] a_edge [S];
  logic signed [WGT_DATA_WIDTH-1:0] w_edge [S];
  logic signed [ACT_DATA_WIDTH-1:0] a_in_arr [S][S];
  logic signed [WGT_DATA_WIDTH-1:0] w_in_arr [S][S];
  logic signed [ACT_DATA_WIDTH-1:0] a_pipe [S][S];
  logic signed [WGT_DATA_WIDTH-1:0] w_pipe [S][S];
  logic signed [PE_OUT_WIDTH-1:0]   acc_arr [S][S];

  // N arrives on the first LOAD edge, so that edge uses it straight from the SP bus.
  logic [DIM_W-1:0] n_now, last_t;
  logic [15:0]      mk, kn, ld_len, idx_nx;
  logic signed [PE_OUT_WIDTH-1:0] acc_sel;

  assign n_now   = (state == LOAD && idx == 16'd0) ? clamp_dim(data_out_sp_bram, S) : cfg.n;
  assign mk      = 16'(cfg.m) * 16'(cfg.k);
  assign kn      = 16'(cfg.k) * 16'(n_now);
  assign ld_len  = (mk > kn) ? mk : kn;
  assign idx_nx  = idx + 16'd1;
  assign last_t  = cfg.m + cfg.k + cfg.n - DIM_W'(3);
  assign acc_sel = acc_arr[om[IW-1:0]][on[IW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cfg <= '0;
      cfg_cnt <= '0;
      done_ph <= '0;
      holdoff <= 1'b0;
      idx <= '0;
      {am, ak, wk, wn, t, om, on} <= '0;
      {a_cap_vld, w_cap_vld} <= '0;
      {a_cap_r, a_cap_c, w_cap_r, w_cap_c} <= '0;
      addr_sp_bram <= SP_START;
      enable_sp_bram <= 1'b1;
      w_enable_sp_bram <= '0;
      data_in_sp_bram <= '0;
      addr_a_bram <= '0;
      enable_a_bram <= 1'b0;
      addr_w_bram <= '0;
      enable_w_bram <= 1'b0;
      addr_o_bram <= '0;
      enable_o_bram <= 1'b0;
      w_enable_o_bram <= '0;
      data_in_o_bram <= '0;
    end else begin
      a_cap_vld <= 1'b0;
      w_cap_vld <= 1'b0;
      case (state)
        IDLE: begin
          addr_sp_bram <= SP_START;
          enable_sp_bram <= 1'b1;
          w_enable_sp_bram <= '0;
          data_in_sp_bram <= '0;
          holdoff <= 1'b0;
          // The first read after clearing start may return the stale flag.
          if (!holdoff && data_out_sp_bram == 32'd1) begin
            state <= CFG;
            addr_sp_bram <= SP_MODE;
            cfg_cnt <= '0;
          end
        end
        CFG: begin
          cfg_cnt <= cfg_cnt + 2'd1;
          case (cfg_cnt)
            2'd0: addr_sp_bram <= SP_M;
            2'd1: begin
              cfg.mode <= data_out_sp_bram[0];
              addr_sp_bram <= SP_K;
            end
            2'd2: begin
              cfg.m <= clamp_dim(data_out_sp_bram, S);
              addr_sp_bram <= SP_N;
            end
            default: begin
              cfg.k <= clamp_dim(data_out_sp_bram, S);
              state <= LOAD;
              idx <= '0;
              {am, ak, wk, wn} <= '0;
              addr_a_bram <= '0;
              addr_w_bram <= '0;
              enable_a_bram <= 1'b1;
              enable_w_bram <= 1'b1;
            end
          endcase
        end
        LOAD: begin
          if (idx == 16'd0) begin
            cfg.n <= n_now;
            enable_sp_bram <= 1'b0;
            addr_sp_bram <= '0;
          end
          a_cap_vld <= enable_a_bram;
          a_cap_r <= am;
          a_cap_c <= ak;
          w_cap_vld <= enable_w_bram;
          w_cap_r <= wk;
          w_cap_c <= wn;
          if (ak + DIM_W'(1) == cfg.k) begin ak <= '0; am <= am + DIM_W'(1); end
          else ak <= ak + DIM_W'(1);
          if (wn + DIM_W'(1) == n_now) begin wn <= '0; wk <= wk + DIM_W'(1); end
          else wn <= wn + DIM_W'(1);
          // One extra cycle with enables low lets the last read land in the buffers.
          if (idx < ld_len) begin
            idx <= idx_nx;
            if (idx_nx < ld_len) begin
              addr_a_bram <= 32'(idx_nx) << 2;
              addr_w_bram <= 32'(idx_nx) << 2;
              enable_a_bram <= (idx_nx < mk);
              enable_w_bram <= (idx_nx < kn);
            end else begin
              addr_a_bram <= '0;
              addr_w_bram <= '0;
              enable_a_bram <= 1'b0;
              enable_w_bram <= 1'b0;
            end
          end else begin
            state <= COMPUTE;
            t <= '0;
          end
        end
        COMPUTE: begin
          if (t == last_t) begin
            state <= WRITE;
            om <= '0;
            on <= '0;
          end else begin
            t <= t + DIM_W'(1);
          end
        end
        WRITE: begin
          enable_o_bram <= 1'b1;
          w_enable_o_bram <= 4'b1111;
          addr_o_bram <= (32'(om) * 32'(cfg.n) + 32'(on)) << 2;
          data_in_o_bram <= 32'(acc_sel);
          if (on + DIM_W'(1) == cfg.n) begin
            on <= '0;
            if (om + DIM_W'(1) == cfg.m) begin
              state <= DONE;
              done_ph <= '0;
            end else begin
              om <= om + DIM_W'(1);
            end
          end else begin
            on <= on + DIM_W'(1);
          end
        end
        DONE: begin
          enable_o_bram <= 1'b0;
          w_enable_o_bram <= '0;
          addr_o_bram <= '0;
          data_in_o_bram <= '0;
          enable_sp_bram <= 1'b1;
          done_ph <= done_ph + 2'd1;
          case (done_ph)
            2'd0: begin
              addr_sp_bram <= SP_DONE;
              w_enable_sp_bram <= 4'b1111;
              data_in_sp_bram <= 32'd1;
            end
            2'd1: begin
              addr_sp_bram <= SP_START;
              w_enable_sp_bram <= 4'b1111;
              data_in_sp_bram <= 32'd0;
            end
            default: begin
              addr_sp_bram <= SP_START;
              w_enable_sp_bram <= '0;
              data_in_sp_bram <= '0;
              state <= IDLE;
              holdoff <= 1'b1;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (a_cap_vld) a_buf[a_cap_r[IW-1:0]][a_cap_c[IW-1:0]] <= data_out_a_bram[ACT_DATA_WIDTH-1:0];
    if (w_cap_vld) w_buf[w_cap_r[IW-1:0]][w_cap_c[IW-1:0]] <= data_out_w_bram[WGT_DATA_WIDTH-1:0];
  end

  // Row r / column c start r / c cycles late so A[r][k] and W[k][c] meet in PE[r][c].
  // WS walks the reduction index in reverse; the accumulated sum does not depend on order.
  always_comb begin
    int kk, kmap;
    for (int r = 0; r < S; r++) begin
      a_edge[r] = '0;
      w_edge[r] = '0;
      kk = int'(t) - r;
      kmap = (cfg.mode == MODE_WS) ? int'(cfg.k) - 1 - kk : kk;
      if (state == COMPUTE && kk >= 0 && kk < int'(cfg.k)) begin
        if (r < int'(cfg.m)) a_edge[r] = a_buf[r][kmap[IW-1:0]];
        if (r < int'(cfg.n)) w_edge[r] = w_buf[kmap[IW-1:0]][r];
      end
    end
  end

  for (genvar gr = 0; gr < S; gr++) begin : g_row
    for (genvar gc = 0; gc < S; gc++) begin : g_col
      if (gc == 0) begin : g_aedge
        assign a_in_arr[gr][gc] = a_edge[gr];
      end else begin : g_apipe
        assign a_in_arr[gr][gc] = a_pipe[gr][gc-1];
      end
      if (gr == 0) begin : g_wedge
        assign w_in_arr[gr][gc] = w_edge[gc];
      end else begin : g_wpipe
        assign w_in_arr[gr][gc] = w_pipe[gr-1][gc];
      end
      mat_mul_pe #(
        .ACT_DATA_WIDTH(ACT_DATA_WIDTH),
        .WGT_DATA_WIDTH(WGT_DATA_WIDTH),
        .PE_OUT_WIDTH  (PE_OUT_WIDTH)
      ) u_pe (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (state == LOAD),
        .en     (state == COMPUTE),
        .a_in   (a_in_arr[gr][gc]),
        .w_in   (w_in_arr[gr][gc]),
        .a_out  (a_pipe[gr][gc]),
        .w_out  (w_pipe[gr][gc]),
        .acc    (acc_arr[gr][gc])
      );
    end
  end

  logic unused_ok;
  always_comb begin
    unused_ok = ^{data_out_a_bram[31:ACT_DATA_WIDTH], data_out_w_bram[31:WGT_DATA_WIDTH]};
    for (int i = 0; i < S; i++) unused_ok = unused_ok ^ (^a_pipe[i][S-1]) ^ (^w_pipe[S-1][i]);
  end

endmodule

// File: tb/tb_mat_mul_system.sv
// Directed bench for mat_mul_system with BRAM models and a plain-arithmetic reference of O = A*W.
module tb_mat_mul_system;

  localparam int PAT_ONES = 0;
  localparam int PAT_CNT  = 1;
  localparam int PAT_NEG  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] addr_sp_bram, data_out_sp_bram, data_in_sp_bram;
  logic        enable_sp_bram;
  logic [3:0]  w_enable_sp_bram;
  logic [31:0] addr_a_bram, data_out_a_bram;
  logic        enable_a_bram;
  logic [31:0] addr_w_bram, data_out_w_bram;
  logic        enable_w_bram;
  logic [31:0] addr_o_bram, data_in_o_bram;
  logic        enable_o_bram;
  logic [3:0]  w_enable_o_bram;

  always #5 clk = ~clk;

  mat_mul_system dut (
    .clk(clk), .reset_n(reset_n),
    .addr_sp_bram(addr_sp_bram), .enable_sp_bram(enable_sp_bram), .data_out_sp_bram(data_out_sp_bram),
    .w_enable_sp_bram(w_enable_sp_bram), .data_in_sp_bram(data_in_sp_bram),
    .addr_a_bram(addr_a_bram), .enable_a_bram(enable_a_bram), .data_out_a_bram(data_out_a_bram),
    .addr_w_bram(addr_w_bram), .enable_w_bram(enable_w_bram), .data_out_w_bram(data_out_w_bram),
    .addr_o_bram(addr_o_bram), .enable_o_bram(enable_o_bram), .w_enable_o_bram(w_enable_o_bram),
    .data_in_o_bram(data_in_o_bram)
  );

  logic [31:0] sp_mem [32];
  logic [31:0] a_mem [64];
  logic [31:0] w_mem [64];
  logic [31:0] o_mem [64];
  int          o_cnt [64];
  int          want_o [64];
  int total = 0, bad = 0;
  int exp_m, exp_k, exp_n, wr_idx, sp_wr_n, cyc = 0, last_ld_cyc, last_wr_cyc;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)", name, act, act, req, req);
    end
  endtask

  function automatic int clampd(input int raw);
    if (raw < 1) return 1;
    if (raw > 8) return 8;
    return raw;
  endfunction

  function automatic int sx8(input logic [31:0] w);
    byte b;
    b = w[7:0];
    return int'(b);
  endfunction

  // Read-first single-cycle BRAM models.
  initial data_out_sp_bram = '0;
  initial data_out_a_bram = '0;
  initial data_out_w_bram = '0;
  always @(posedge clk) begin
    cyc++;
    if (enable_sp_bram) begin
      data_out_sp_bram <= sp_mem[addr_sp_bram[6:2]];
      if (w_enable_sp_bram == 4'hF) sp_mem[addr_sp_bram[6:2]] = data_in_sp_bram;
    end
    if (enable_a_bram) data_out_a_bram <= a_mem[addr_a_bram[7:2]];
    if (enable_w_bram) data_out_w_bram <= w_mem[addr_w_bram[7:2]];
    if (enable_o_bram && w_enable_o_bram == 4'hF) begin
      o_mem[addr_o_bram[7:2]] = data_in_o_bram;
      o_cnt[addr_o_bram[7:2]] = o_cnt[addr_o_bram[7:2]] + 1;
    end
  end

  // Every O write must be the next row-major element with the reference value.
  always @(negedge clk) begin
    if (reset_n && chk_on) begin
      if (enable_a_bram || enable_w_bram) last_ld_cyc = cyc;
      if (w_enable_o_bram != 4'h0) begin
        check("o_we", {27'd0, enable_o_bram, w_enable_o_bram}, {27'd0, 1'b1, 4'hF});
        check("o_in_range", 32'(wr_idx < exp_m * exp_n), 32'd1);
        if (wr_idx < 64) begin
          check("o_addr", addr_o_bram, 32'(wr_idx * 4));
          check("o_data", data_in_o_bram, want_o[wr_idx]);
        end
        wr_idx++;
        last_wr_cyc = cyc;
      end
      if (w_enable_sp_bram != 4'h0) begin
        check("sp_we", {28'd0, w_enable_sp_bram}, 32'hF);
        check("sp_addr", addr_sp_bram, (sp_wr_n == 0) ? 32'd100 : 32'd0);
        check("sp_data", data_in_sp_bram, (sp_wr_n == 0) ? 32'd1 : 32'd0);
        sp_wr_n++;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_sp"}, {addr_sp_bram[7:0], 3'd0, enable_sp_bram, w_enable_sp_bram}, 32'h00000010);
    check({tag, "_sp_din"}, data_in_sp_bram, 32'd0);
    check({tag, "_aw"}, {30'd0, enable_a_bram, enable_w_bram} | addr_a_bram | addr_w_bram, 32'd0);
    check({tag, "_o"}, {27'd0, enable_o_bram, w_enable_o_bram} | addr_o_bram | data_in_o_bram, 32'd0);
  endtask

  task automatic run_job(input int mode, input int m_raw, input int k_raw, input int n_raw,
                         input int pat, input bit watch, input bit abort);
    int s;
    bit seen;
    @(negedge clk);
    sp_mem[1] = mode; sp_mem[2] = m_raw; sp_mem[3] = k_raw; sp_mem[4] = n_raw; sp_mem[25] = 0;
    exp_m = clampd(m_raw); exp_k = clampd(k_raw); exp_n = clampd(n_raw);
    for (int i = 0; i < 64; i++) begin
      a_mem[i] = 0; w_mem[i] = 0; o_mem[i] = 0; o_cnt[i] = 0; want_o[i] = 0;
    end
    for (int m = 0; m < exp_m; m++)
      for (int k = 0; k < exp_k; k++)
        case (pat)
          PAT_ONES: a_mem[m*exp_k+k] = 32'd1;
          PAT_CNT:  a_mem[m*exp_k+k] = 32'((m+1)*10 + (k+1));
          default:  a_mem[m*exp_k+k] = {24'hA5A5A5, 8'(-(k+1))};
        endcase
    for (int k = 0; k < exp_k; k++)
      for (int n = 0; n < exp_n; n++)
        case (pat)
          PAT_ONES: w_mem[k*exp_n+n] = 32'd1;
          PAT_CNT:  w_mem[k*exp_n+n] = 32'((k+1)*10 + (n+1));
          default:  w_mem[k*exp_n+n] = {24'h5A5A5A, 8'(k-n)};
        endcase
    for (int m = 0; m < exp_m; m++)
      for (int n = 0; n < exp_n; n++)
        for (int k = 0; k < exp_k; k++)
          want_o[m*exp_n+n] += sx8(a_mem[m*exp_k+k]) * sx8(w_mem[k*exp_n+n]);
    wr_idx = 0; sp_wr_n = 0; last_ld_cyc = 0; last_wr_cyc = 0; chk_on = 1'b1;
    sp_mem[0] = 1;
    if (watch) begin
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (addr_sp_bram == 32'd4) seen = 1'b1;
      end
      check("cfg_addr4_seen", 32'(seen), 32'd1);
      @(negedge clk) check("cfg_addr8", addr_sp_bram, 32'd8);
      @(negedge clk) check("cfg_addr12", addr_sp_bram, 32'd12);
      @(negedge clk) check("cfg_addr16", addr_sp_bram, 32'd16);
      @(negedge clk) check("load_first", {addr_a_bram[29:0], enable_a_bram, enable_w_bram} | addr_w_bram, 32'd3);
    end
    if (abort) begin
      seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
        @(negedge clk);
        if (enable_o_bram) seen = 1'b1;
      end
      check("abort_write_seen", 32'(seen), 32'd1);
      repeat (3) @(negedge clk);
      reset_n = 1'b0; chk_on = 1'b0; sp_mem[0] = 0;
      @(negedge clk) check_reset_vals("abort_rst");
      @(negedge clk) reset_n = 1'b1;
      return;
    end
    s = 0;
    while (s < 3000 && sp_mem[25] != 1) begin
      @(negedge clk);
      s++;
    end
    check("done_flag", sp_mem[25], 32'd1);
    repeat (4) @(negedge clk);
    check("start_cleared", sp_mem[0], 32'd0);
    check("o_write_count", 32'(wr_idx), 32'(exp_m * exp_n));
    for (int i = 0; i < 64; i++)
      check("o_once", 32'(o_cnt[i]), (i < exp_m * exp_n) ? 32'd1 : 32'd0);
    check("o_latency_ok", 32'(last_wr_cyc - last_ld_cyc <= 151), 32'd1);
    chk_on = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) sp_mem[i] = 0;
    for (int i = 0; i < 64; i++) begin
      a_mem[i] = 0; w_mem[i] = 0; o_mem[i] = 0; o_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_sp", {addr_sp_bram[30:0], enable_sp_bram}, 32'd1);
      check("idle_en", {29'd0, enable_a_bram, enable_w_bram, enable_o_bram}, 32'd0);
    end

    run_job(1, 6, 5, 4, PAT_ONES, 1'b1, 1'b0);
    check("ones_o0", o_mem[0], 32'd5);
    check("ones_o23", o_mem[23], 32'd5);

    run_job(1, 6, 5, 4, PAT_CNT, 1'b0, 1'b0);
    check("model_o00", want_o[0], 32'd2115);
    check("model_o53", want_o[23], 32'd10810);
    check("os_o00", o_mem[0], 32'd2115);

    run_job(0, 6, 5, 4, PAT_CNT, 1'b0, 1'b0);
    check("ws_o00", o_mem[0], 32'd2115);
    check("ws_o53", o_mem[23], 32'd10810);

    run_job(0, 0, 20, 3, PAT_NEG, 1'b0, 1'b0);
    check("model_neg_o00", want_o[0], 32'hFFFFFF58);
    check("clamp_neg_o00", o_mem[0], 32'hFFFFFF58);

    run_job(1, 6, 5, 4, PAT_CNT, 1'b0, 1'b1);
    run_job(0, 6, 5, 4, PAT_CNT, 1'b0, 1'b0);
    check("after_abort_o00", o_mem[0], 32'd2115);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
